// File: rtl/tlb_lookup_ctrl.sv
// TLB requester-side controller: lookup, page walk, victim fill, LRU aging.
// Optional `TLB_PERM_CHECK_EN enables read/write permission faults.
module tlb_lookup_ctrl #(
    parameter int NUM_SETS       = 16,
    parameter int NUM_WAYS       = 4,
    parameter int SET_INDEX_BITS = 4,
    parameter int LRU_BITS       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_vaddr,
    input  logic                         req_is_write,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp_hit,
    output logic [19:0]                  resp_ppn,
    output logic                         resp_fault,
    output logic                         walk_req_valid,
    input  logic                         walk_req_ready,
    output logic [19:0]                  walk_req_vpn,
    input  logic                         walk_resp_valid,
    input  logic [19:0]                  walk_resp_ppn,
    input  logic [1:0]                   walk_resp_perms,
    input  logic                         walk_resp_fault,
    output logic [SET_INDEX_BITS-1:0]    rd_set_index,
    input  logic [NUM_WAYS-1:0]          rd_valid,
    input  logic [NUM_WAYS*20-1:0]       rd_vpn,
    input  logic [NUM_WAYS*20-1:0]       rd_ppn,
    input  logic [NUM_WAYS*2-1:0]        rd_perms,
    input  logic [NUM_WAYS*LRU_BITS-1:0] rd_lru_count,
    output logic                         wr_en,
    output logic [SET_INDEX_BITS-1:0]    wr_set_index,
    output logic [1:0]                   wr_way,
    output logic                         wr_valid,
    output logic [19:0]                  wr_vpn,
    output logic [19:0]                  wr_ppn,
    output logic [1:0]                   wr_perms,
    output logic [LRU_BITS-1:0]          wr_lru_count,
    output logic                         lru_update_en,
    output logic [SET_INDEX_BITS-1:0]    lru_set_index,
    output logic [1:0]                   lru_way,
    output logic [LRU_BITS-1:0]          lru_value
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WALK_REQ  = 3'd2;
    localparam logic [2:0] S_WALK_WAIT = 3'd3;
    localparam logic [2:0] S_FILL      = 3'd4;
    localparam logic [2:0] S_AGE       = 3'd5;
    localparam logic [2:0] S_RESP      = 3'd6;

    logic [2:0]                           r_state;
    logic [19:0]                          r_vpn;
    logic                                 r_is_write;
    logic [NUM_WAYS-1:0]                  r_snap_valid;
    logic [NUM_WAYS-1:0][LRU_BITS-1:0]    r_snap_lru;
    logic [1:0]                           r_target;
    logic [LRU_BITS-1:0]                  r_old;
    logic [1:0]                           r_age_w;
    logic                                 r_hit;
    logic                                 r_fault;
    logic [19:0]                          r_ppn;
    logic [1:0]                           r_perms;

    logic [SET_INDEX_BITS-1:0] w_set;
    logic                      w_hit;
    logic [1:0]                w_hit_way;
    logic [19:0]               w_hit_ppn;
    logic [1:0]                w_hit_perms;
    logic [LRU_BITS-1:0]       w_hit_lru;
    logic                      w_inv_found;
    logic [1:0]                w_inv_way;
    logic [1:0]                w_max_way;
    logic [LRU_BITS-1:0]       w_max_cnt;
    logic [1:0]                w_victim;
    logic [LRU_BITS-1:0]       w_age_cnt;
    logic                      w_age_en;
    logic [LRU_BITS-1:0]       w_age_val;
    logic                      w_unused;

    assign w_set    = SET_INDEX_BITS'(32'(r_vpn) % NUM_SETS);
    assign w_unused = ^{req_vaddr[11:0], r_is_write};

    // Descending scan so the lowest matching way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_hit_ppn   = '0;
        w_hit_perms = '0;
        w_hit_lru   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (rd_valid[i] && rd_vpn[i*20 +: 20] == r_vpn) begin
                w_hit       = 1'b1;
                w_hit_way   = 2'(i);
                w_hit_ppn   = rd_ppn[i*20 +: 20];
                w_hit_perms = rd_perms[i*2 +: 2];
                w_hit_lru   = rd_lru_count[i*LRU_BITS +: LRU_BITS];
            end
        end
    end

    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_max_way   = '0;
        w_max_cnt   = r_snap_lru[0];
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!r_snap_valid[i]) begin
                w_inv_found = 1'b1;
                w_inv_way   = 2'(i);
            end
        end
        for (int i = 1; i < NUM_WAYS; i++) begin
            if (r_snap_lru[i] > w_max_cnt) begin
                w_max_cnt = r_snap_lru[i];
                w_max_way = 2'(i);
            end
        end
        w_victim = w_inv_found ? w_inv_way : w_max_way;
    end

    always_comb begin
        w_age_cnt = r_snap_lru[r_age_w];
        w_age_en  = 1'b0;
        w_age_val = '0;
        if (r_age_w == r_target) begin
            w_age_en = 1'b1;
        end else if (r_snap_valid[r_age_w] && w_age_cnt < r_old) begin
            w_age_en  = 1'b1;
            w_age_val = (w_age_cnt >= LRU_BITS'(NUM_WAYS - 1)) ?
                        LRU_BITS'(NUM_WAYS - 1) : w_age_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vpn        <= '0;
            r_is_write   <= 1'b0;
            r_snap_valid <= '0;
            r_snap_lru   <= '0;
            r_target     <= '0;
            r_old        <= '0;
            r_age_w      <= '0;
            r_hit        <= 1'b0;
            r_fault      <= 1'b0;
            r_ppn        <= '0;
            r_perms      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (req_valid) begin
                    r_vpn      <= req_vaddr[31:12];
                    r_is_write <= req_is_write;
                    r_hit      <= 1'b0;
                    r_fault    <= 1'b0;
                    r_ppn      <= '0;
                    r_state    <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    r_snap_valid <= rd_valid;
                    r_snap_lru   <= rd_lru_count;
                    r_age_w      <= '0;
                    if (w_hit) begin
                        r_target <= w_hit_way;
                        r_old    <= w_hit_lru;
                        r_hit    <= 1'b1;
                        r_ppn    <= w_hit_ppn;
                        r_perms  <= w_hit_perms;
`ifdef TLB_PERM_CHECK_EN
                        r_fault  <= r_is_write ? !w_hit_perms[1] : !w_hit_perms[0];
`endif
                        r_state  <= S_AGE;
                    end else begin
                        r_state  <= S_WALK_REQ;
                    end
                end
                S_WALK_REQ: if (walk_req_ready) r_state <= S_WALK_WAIT;
                S_WALK_WAIT: if (walk_resp_valid) begin
                    if (walk_resp_fault) begin
                        r_fault <= 1'b1;
                        r_ppn   <= '0;
                        r_state <= S_RESP;
                    end else begin
                        r_ppn   <= walk_resp_ppn;
                        r_perms <= walk_resp_perms;
`ifdef TLB_PERM_CHECK_EN
                        r_fault <= r_is_write ? !walk_resp_perms[1] : !walk_resp_perms[0];
`endif
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_target <= w_victim;
                    r_old    <= '1;
                    r_age_w  <= '0;
                    r_state  <= S_AGE;
                end
                S_AGE: begin
                    r_age_w <= r_age_w + 1'b1;
                    if (r_age_w == 2'(NUM_WAYS - 1)) r_state <= S_RESP;
                end
                S_RESP: if (resp_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready      = (r_state == S_IDLE);
        rd_set_index   = w_set;
        walk_req_valid = (r_state == S_WALK_REQ);
        walk_req_vpn   = walk_req_valid ? r_vpn : '0;
        wr_en          = (r_state == S_FILL);
        wr_set_index   = wr_en ? w_set : '0;
        wr_way         = wr_en ? w_victim : '0;
        wr_valid       = wr_en;
        wr_vpn         = wr_en ? r_vpn : '0;
        wr_ppn         = wr_en ? r_ppn : '0;
        wr_perms       = wr_en ? r_perms : '0;
        wr_lru_count   = '0;
        lru_update_en  = (r_state == S_AGE) && w_age_en;
        lru_set_index  = (r_state == S_AGE) ? w_set : '0;
        lru_way        = (r_state == S_AGE) ? r_age_w : '0;
        lru_value      = lru_update_en ? w_age_val : '0;
        resp_valid     = (r_state == S_RESP);
        resp_hit       = resp_valid && r_hit;
        resp_fault     = resp_valid && r_fault;
        resp_ppn       = (resp_valid && !r_fault) ? r_ppn : '0;
    end

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Scoreboard bench for tlb_lookup_ctrl with a behavioural tlb_storage model.
// Covers miss/fill, hit latency, eviction, walk fault, backpressure, reset.
module tb_tlb_lookup_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_write;
    logic [31:0] req_vaddr;
    logic        resp_valid, resp_ready, resp_hit, resp_fault;
    logic [19:0] resp_ppn;
    logic        walk_req_valid, walk_req_ready;
    logic [19:0] walk_req_vpn;
    logic        walk_resp_valid, walk_resp_fault;
    logic [19:0] walk_resp_ppn;
    logic [1:0]  walk_resp_perms;
    logic [3:0]  rd_set_index;
    logic [3:0]  rd_valid;
    logic [79:0] rd_vpn, rd_ppn;
    logic [7:0]  rd_perms;
    logic [15:0] rd_lru_count;
    logic        wr_en, wr_valid;
    logic [3:0]  wr_set_index;
    logic [1:0]  wr_way, wr_perms;
    logic [19:0] wr_vpn, wr_ppn;
    logic [3:0]  wr_lru_count;
    logic        lru_update_en;
    logic [3:0]  lru_set_index;
    logic [1:0]  lru_way;
    logic [3:0]  lru_value;

    always #5 clk = ~clk;

    tlb_lookup_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .req_is_write(req_is_write),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_ppn(resp_ppn), .resp_fault(resp_fault),
        .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
        .walk_req_vpn(walk_req_vpn),
        .walk_resp_valid(walk_resp_valid), .walk_resp_ppn(walk_resp_ppn),
        .walk_resp_perms(walk_resp_perms), .walk_resp_fault(walk_resp_fault),
        .rd_set_index(rd_set_index), .rd_valid(rd_valid), .rd_vpn(rd_vpn),
        .rd_ppn(rd_ppn), .rd_perms(rd_perms), .rd_lru_count(rd_lru_count),
        .wr_en(wr_en), .wr_set_index(wr_set_index), .wr_way(wr_way),
        .wr_valid(wr_valid), .wr_vpn(wr_vpn), .wr_ppn(wr_ppn),
        .wr_perms(wr_perms), .wr_lru_count(wr_lru_count),
        .lru_update_en(lru_update_en), .lru_set_index(lru_set_index),
        .lru_way(lru_way), .lru_value(lru_value)
    );

    // Storage model: combinational read, registered write and LRU ports.
    logic        m_valid [16][4];
    logic [19:0] m_vpn   [16][4];
    logic [19:0] m_ppn   [16][4];
    logic [1:0]  m_perms [16][4];
    logic [3:0]  m_lru   [16][4];

    always_comb begin
        rd_valid     = '0;
        rd_vpn       = '0;
        rd_ppn       = '0;
        rd_perms     = '0;
        rd_lru_count = '0;
        for (int w = 0; w < 4; w++) begin
            rd_valid[w]         = m_valid[rd_set_index][w];
            rd_vpn[w*20 +: 20]  = m_vpn[rd_set_index][w];
            rd_ppn[w*20 +: 20]  = m_ppn[rd_set_index][w];
            rd_perms[w*2 +: 2]  = m_perms[rd_set_index][w];
            rd_lru_count[w*4 +: 4] = m_lru[rd_set_index][w];
        end
    end

    always @(posedge clk) begin
        if (wr_en) begin
            m_valid[wr_set_index][wr_way] <= wr_valid;
            m_vpn[wr_set_index][wr_way]   <= wr_vpn;
            m_ppn[wr_set_index][wr_way]   <= wr_ppn;
            m_perms[wr_set_index][wr_way] <= wr_perms;
            m_lru[wr_set_index][wr_way]   <= wr_lru_count;
        end
        if (lru_update_en)
            m_lru[lru_set_index][lru_way] <= lru_value;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        hit;
        logic [19:0] ppn;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    int resp_done = 0;
    int resp_edge = 0;
    int acc_edge = 0;
    int wr_cnt = 0;
    int walk_cnt = 0;
    logic [3:0] last_wr_set;
    logic [1:0] last_wr_way;
    logic [3:0] last_wr_lru;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_en) begin
                    wr_cnt++;
                    last_wr_set = wr_set_index;
                    last_wr_way = wr_way;
                    last_wr_lru = wr_lru_count;
                end
                if (walk_req_valid && walk_req_ready) walk_cnt++;
                if (wr_en && lru_update_en) begin
                    failures++;
                    $display("FAIL wr_lru_overlap actual=1 required=0");
                end
                if (resp_valid && resp_ready) begin
                    resp_edge = cyc + 1;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_resp", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("resp_hit", resp_hit, e.hit);
                        chk("resp_ppn", resp_ppn, e.ppn);
                        chk("resp_fault", resp_fault, e.fault);
                    end
                    resp_done++;
                end
            end
        end
    end

    task automatic do_req(
        input logic [31:0] va, input logic wr, input logic exp_walk,
        input logic [19:0] w_ppn, input logic [1:0] w_perms,
        input logic w_fault, input int walk_stall, input int resp_stall,
        input logic e_hit, input logic [19:0] e_ppn, input logic e_fault);
        int n;
        int done0;
        int walk0;
        exp_t e;
        done0 = resp_done;
        walk0 = walk_cnt;
        e = '{hit: e_hit, ppn: e_ppn, fault: e_fault};
        sb_q.push_back(e);
        resp_ready   = (resp_stall == 0);
        req_vaddr    = va;
        req_is_write = wr;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        acc_edge  = cyc;
        req_valid = 1'b0;
        if (exp_walk) begin
            n = 0;
            @(negedge clk);
            while (!walk_req_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("walk_req_valid", walk_req_valid, 1);
            chk("walk_req_vpn", walk_req_vpn, va[31:12]);
            for (int i = 0; i < walk_stall; i++) begin
                @(negedge clk);
                chk("walk_hold_valid", walk_req_valid, 1);
                chk("walk_hold_vpn", walk_req_vpn, va[31:12]);
            end
            @(posedge clk);
            #1 walk_req_ready = 1'b1;
            @(posedge clk);
            #1 walk_req_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            walk_resp_valid = 1'b1;
            walk_resp_ppn   = w_ppn;
            walk_resp_perms = w_perms;
            walk_resp_fault = w_fault;
            @(posedge clk);
            #1;
            walk_resp_valid = 1'b0;
            walk_resp_ppn   = '0;
            walk_resp_perms = '0;
            walk_resp_fault = 1'b0;
        end
        if (resp_stall > 0) begin
            n = 0;
            @(negedge clk);
            while (!resp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("resp_valid_seen", resp_valid, 1);
            for (int i = 0; i < resp_stall; i++) begin
                @(negedge clk);
                chk("resp_hold_valid", resp_valid, 1);
                chk("resp_hold_hit", resp_hit, e_hit);
                chk("resp_hold_ppn", resp_ppn, e_ppn);
                chk("resp_hold_fault", resp_fault, e_fault);
            end
            @(posedge clk);
            #1 resp_ready = 1'b1;
        end
        n = 0;
        while (resp_done == done0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("resp_done", resp_done - done0, 1);
        if (resp_done == done0 && sb_q.size() > 0) void'(sb_q.pop_back());
        if (!exp_walk) chk("no_walk", walk_cnt, walk0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int w0;
        logic [19:0] v;
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_vpn[s][w]   = '0;
                m_ppn[s][w]   = '0;
                m_perms[s][w] = '0;
                m_lru[s][w]   = '0;
            end
        rst = 1'b1;
        req_valid = 1'b0; req_vaddr = '0; req_is_write = 1'b0;
        resp_ready = 1'b1; walk_req_ready = 1'b0;
        walk_resp_valid = 1'b0; walk_resp_ppn = '0;
        walk_resp_perms = '0; walk_resp_fault = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_walk_valid", walk_req_valid, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_lru_en", lru_update_en, 0);
        chk("rst_rd_set", rd_set_index, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        w0 = wr_cnt;
        do_req(32'hABCDE123, 0, 1, 20'h12345, 2'b11, 0, 0, 0, 0, 20'h12345, 0);
        chk("miss_wr_cnt", wr_cnt - w0, 1);
        chk("miss_wr_set", last_wr_set, 4'hE);
        chk("miss_wr_way", last_wr_way, 0);
        chk("miss_wr_lru", last_wr_lru, 0);
        chk("miss_stored_vpn", m_vpn[14][0], 20'hABCDE);

        do_req(32'hABCDE123, 0, 0, 0, 0, 0, 0, 0, 1, 20'h12345, 0);
        chk("hit_latency", resp_edge - acc_edge, 6);

        w0 = wr_cnt;
        do_req(32'h55555000, 0, 1, 20'h0AAAA, 2'b11, 1, 0, 0, 0, 20'h0, 1);
        chk("fault_no_wr", wr_cnt - w0, 0);
        chk("fault_set_empty",
            {m_valid[5][3], m_valid[5][2], m_valid[5][1], m_valid[5][0]}, 0);

        for (int i = 0; i < 4; i++) begin
            v = 20'h00003 + 20'(i) * 20'h10;
            do_req({v, 12'h0}, 0, 1, 20'h20000 + 20'(i), 2'b11, 0,
                   (i == 1) ? 5 : 0, 0, 0, 20'h20000 + 20'(i), 0);
        end
        chk("fill_lru_w0", m_lru[3][0], 3);
        chk("fill_lru_w3", m_lru[3][3], 0);
        do_req(32'h00003000, 0, 0, 0, 0, 0, 0, 4, 1, 20'h20000, 0);
        chk("hit_lru_w0", m_lru[3][0], 0);
        chk("hit_lru_w1", m_lru[3][1], 3);
        chk("hit_lru_w3", m_lru[3][3], 1);
        do_req(32'h00043000, 0, 1, 20'h20004, 2'b11, 0, 0, 0, 0, 20'h20004, 0);
        chk("evict_way", last_wr_way, 1);
        chk("evict_vpn", m_vpn[3][1], 20'h00043);
        chk("evict_lru_w0", m_lru[3][0], 1);
        chk("evict_lru_w2", m_lru[3][2], 3);

`ifdef TLB_PERM_CHECK_EN
        do_req(32'h77777000, 1, 1, 20'h31111, 2'b01, 0, 0, 0, 0, 20'h0, 1);
        chk("perm_fill_done", m_valid[7][0], 1);
        do_req(32'h77777000, 1, 0, 0, 0, 0, 0, 0, 1, 20'h0, 1);
        do_req(32'h77777000, 0, 0, 0, 0, 0, 0, 0, 1, 20'h31111, 0);
`else
        do_req(32'h77777000, 1, 1, 20'h31111, 2'b01, 0, 0, 0, 0, 20'h31111, 0);
        do_req(32'h77777000, 1, 0, 0, 0, 0, 0, 0, 1, 20'h31111, 0);
`endif

        req_vaddr = 32'hABCDE123;
        req_is_write = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_lru_en", lru_update_en, 0);
        chk("midrst_lru_way", lru_way, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_wr_en", wr_en, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(32'hABCDE123, 0, 0, 0, 0, 0, 0, 0, 1, 20'h12345, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
